// File: rtl/spi_mult_pkg.sv
// Shared types for the SPI multiply frame controller: word width, FSM states, product type.
// No logic, so no latency; carries no flow control.
package spi_mult_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    GET_B,
    MULT,
    SEND_HI,
    SEND_LO
  } ctrl_state_t;

  typedef logic [2*16-1:0] product_t;

endpackage

// File: rtl/seq_mult_shift_add.sv
// Unsigned shift-add multiplier, W iterations at one per clk; done pulses when the product is final.
// Latency is W cycles from the start edge. There is no backpressure; a new start aborts and restarts.
module seq_mult_shift_add #(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [2*W-1:0]   product,
  output logic             done
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;
  logic           done_q, done_d;

  // The start edge already performs the first iteration, so the product is final W edges after start.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = 1'b0;
    if (start) begin
      mcand_d  = {{W{1'b0}}, a} << 1;
      mplier_d = b >> 1;
      acc_d    = b[0] ? {{W{1'b0}}, a} : '0;
      cnt_d    = LAST_CNT;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  assign product = acc_q;
  assign done    = done_q;

endmodule

// File: rtl/spi_mult_frame_ctrl.sv
// Collects operands A and B from two SPI frames, multiplies them, returns the product high word then low word.
// High word loads DATA_WIDTH+2 cycles after B; paced by tx_done frames, extra frames during MULT flag err_overrun.
module spi_mult_frame_ctrl
  import spi_mult_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_word,
  input  logic                  rx_valid,
  input  logic                  tx_done,
  output logic [DATA_WIDTH-1:0] tx_word,
  output logic                  tx_load,
  output logic                  busy,
  output logic                  result_valid,
  output logic                  err_overrun,
  input  logic                  clear_err
);

  localparam int W = DATA_WIDTH;

  ctrl_state_t    state_q, state_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic           mul_start_q, mul_start_d;
  logic [W-1:0]   tx_word_q, tx_word_d;
  logic           tx_load_q, tx_load_d;
  logic           result_valid_q, result_valid_d;
  logic           err_overrun_q, err_overrun_d;
  logic           busy_q, busy_d;

  logic [2*W-1:0] product;
  logic           mul_done;

  seq_mult_shift_add #(
    .W (W)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start_q),
    .a       (op_a_q),
    .b       (op_b_q),
    .product (product),
    .done    (mul_done)
  );

  always_comb begin
    state_d        = state_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    mul_start_d    = 1'b0;
    tx_word_d      = tx_word_q;
    tx_load_d      = 1'b0;
    result_valid_d = 1'b0;
    err_overrun_d  = err_overrun_q;

    if (clear_err) begin
      err_overrun_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          op_a_d  = rx_word;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (rx_valid) begin
          op_b_d      = rx_word;
          mul_start_d = 1'b1;
          state_d     = MULT;
        end
      end
      MULT: begin
        // A frame landing here has nowhere to go; it is dropped and flagged, the multiply carries on.
        if (rx_valid) begin
          err_overrun_d = 1'b1;
        end
        if (mul_done) begin
          tx_word_d = product[2*W-1:W];
          tx_load_d = 1'b1;
          state_d   = SEND_HI;
        end
      end
      SEND_HI: begin
        if (tx_done) begin
          tx_word_d = product[W-1:0];
          tx_load_d = 1'b1;
          state_d   = SEND_LO;
        end
      end
      SEND_LO: begin
        if (tx_done) begin
          tx_word_d      = '0;
          result_valid_d = 1'b1;
          state_d        = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      op_a_q         <= '0;
      op_b_q         <= '0;
      mul_start_q    <= 1'b0;
      tx_word_q      <= '0;
      tx_load_q      <= 1'b0;
      result_valid_q <= 1'b0;
      err_overrun_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      mul_start_q    <= mul_start_d;
      tx_word_q      <= tx_word_d;
      tx_load_q      <= tx_load_d;
      result_valid_q <= result_valid_d;
      err_overrun_q  <= err_overrun_d;
      busy_q         <= busy_d;
    end
  end

  assign tx_word      = tx_word_q;
  assign tx_load      = tx_load_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign err_overrun  = err_overrun_q;

  a_result_idle : assert property (@(posedge clk) disable iff (!reset) result_valid_q |-> !busy_q);
  a_done_in_mult : assert property (@(posedge clk) disable iff (!reset) mul_done |-> state_q == MULT);

endmodule
